// File: rtl/ma_stage.sv
// Memory-access stage of the TinyRISC pipeline: issues loads/stores over a
// ready-handshake port, stalls upstream while busy and feeds the MA/RW register.
module ma_stage #(
  parameter int unsigned LD_BIT  = 0,
  parameter int unsigned ST_BIT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_op2,
  input  logic [31:0] ex_instr,
  input  logic [21:0] ex_ctrl,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        ma_stall,
  output logic [31:0] rw_pc,
  output logic [31:0] rw_alu,
  output logic [31:0] rw_ld,
  output logic [31:0] rw_instr,
  output logic [21:0] rw_ctrl,
  output logic        err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] instr;
    logic [21:0] ctrl;
  } rw_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
  rw_t         rw_q, rw_d;

  logic is_st, is_ld, mem_op, timeout_hit;

  // A store wins when both control bits are set.
  assign is_st       = ex_ctrl[ST_BIT];
  assign is_ld       = ex_ctrl[LD_BIT] & ~is_st;
  assign mem_op      = is_ld | is_st;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    rw_d        = '0;
    ma_stall    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          ma_stall    = 1'b1;
          state_d     = ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = is_st;
          mem_addr_d  = ex_alu;
          mem_wdata_d = ex_op2;
          cnt_d       = '0;
        end else begin
          rw_d = {ex_pc, ex_alu, 32'h0, ex_instr, ex_ctrl};
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          rw_d      = {ex_pc, ex_alu, (is_ld ? mem_rdata : 32'h0), ex_instr, ex_ctrl};
        end else if (timeout_hit) begin
          // Release the stall on the abort edge so the instruction leaves EX/MA
          // instead of being re-issued from IDLE.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          rw_d      = {ex_pc, ex_alu, 32'h0, ex_instr, ex_ctrl};
        end else begin
          ma_stall = 1'b1;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      rw_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      rw_q        <= rw_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign rw_pc     = rw_q.pc;
  assign rw_alu    = rw_q.alu;
  assign rw_ld     = rw_q.ld;
  assign rw_instr  = rw_q.instr;
  assign rw_ctrl   = rw_q.ctrl;

endmodule

// File: tb/tb_ma_stage.sv
// Scoreboard bench for ma_stage: a driver models the EX/MA register, a responder
// models data memory, and a monitor compares MA/RW against queued expectations.
module tb_ma_stage;

  localparam int T_OUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_pc, ex_alu, ex_op2, ex_instr;
  logic [21:0] ex_ctrl;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ma_stall, err;
  logic [31:0] rw_pc, rw_alu, rw_ld, rw_instr;
  logic [21:0] rw_ctrl;

  always #5 clk = ~clk;

  ma_stage #(.LD_BIT(0), .ST_BIT(1), .TIMEOUT(T_OUT)) dut (
    .clk(clk), .rst(rst),
    .ex_pc(ex_pc), .ex_alu(ex_alu), .ex_op2(ex_op2), .ex_instr(ex_instr), .ex_ctrl(ex_ctrl),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ma_stall(ma_stall),
    .rw_pc(rw_pc), .rw_alu(rw_alu), .rw_ld(rw_ld), .rw_instr(rw_instr), .rw_ctrl(rw_ctrl),
    .err(err)
  );

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] instr;
    logic [21:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          rsp_lat = 0;
  logic [31:0] rsp_data = '0;
  logic        late_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each expectation carries the edge count at which it must appear.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("rw_pc",    rw_pc,         e.pc);
        check("rw_alu",   rw_alu,        e.alu);
        check("rw_ld",    rw_ld,         e.ld);
        check("rw_instr", rw_instr,      e.instr);
        check("rw_ctrl",  32'(rw_ctrl),  32'(e.ctrl));
      end
    end
  end

  // Data memory: pulses ready in the rsp_lat-th cycle of a request (0 = never).
  initial begin
    int rcnt;
    rcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        rcnt++;
        if (rsp_lat != 0 && rcnt == rsp_lat) begin
          mem_ready = 1'b1;
          mem_rdata = rsp_data;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        rcnt      = 0;
        mem_ready = late_pulse;
        mem_rdata = $urandom;
      end
    end
  end

  task automatic drive_nop();
    ex_pc    = '0;
    ex_alu   = '0;
    ex_op2   = '0;
    ex_instr = '0;
    ex_ctrl  = '0;
  endtask

  // Presents one instruction in EX/MA, queues its expected MA/RW stream, checks
  // the handshake cycle by cycle and returns just after the edge it leaves on.
  task automatic exec(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] op2,
                      input logic [31:0] instr, input logic [21:0] ctrl,
                      input int lat, input logic [31:0] rdata);
    logic st, ld, mop;
    int   nb, c0;
    exp_t e;
    st  = ctrl[1];
    ld  = ctrl[0] & ~st;
    mop = ctrl[0] | ctrl[1];
    c0  = cyc;
    ex_pc = pc; ex_alu = alu; ex_op2 = op2; ex_instr = instr; ex_ctrl = ctrl;
    rsp_lat  = lat;
    rsp_data = rdata;
    if (!mop) begin
      e = '{due: c0 + 1, pc: pc, alu: alu, ld: 32'h0, instr: instr, ctrl: ctrl};
      sb.push_back(e);
      @(negedge clk);
      check("stall_alu", 32'(ma_stall), 32'd0);
      check("req_alu",   32'(mem_req),  32'd0);
    end else begin
      nb = (lat == 0) ? T_OUT : lat;
      for (int i = 1; i <= nb; i++) begin
        e = '{due: c0 + i, pc: 32'h0, alu: 32'h0, ld: 32'h0, instr: 32'h0, ctrl: 22'h0};
        sb.push_back(e);
      end
      e = '{due: c0 + nb + 1, pc: pc, alu: alu, ld: ((lat != 0 && ld) ? rdata : 32'h0),
            instr: instr, ctrl: ctrl};
      sb.push_back(e);
      for (int i = 1; i <= nb + 1; i++) begin
        @(negedge clk);
        check("mem_req", 32'(mem_req), 32'(i >= 2));
        if (i <= nb)       check("stall_hi", 32'(ma_stall), 32'd1);
        else if (lat != 0) check("stall_lo", 32'(ma_stall), 32'd0);
        if (i == 2) begin
          check("mem_addr", mem_addr,     alu);
          check("mem_we",   32'(mem_we),  32'(st));
          if (st) check("mem_wdata", mem_wdata, op2);
        end
      end
    end
    @(posedge clk);
    #1;
    drive_nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive_nop();
    #3;
    check("rst_mem_req", 32'(mem_req),  32'd0);
    check("rst_err",     32'(err),      32'd0);
    check("rst_stall",   32'(ma_stall), 32'd0);
    check("rst_rw_alu",  rw_alu,        32'd0);
    check("rst_rw_ctrl", 32'(rw_ctrl),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exec(32'h100, 32'h1234, 32'h0, 32'h13, 22'h000004, 0, 32'h0);
    exec(32'h104, 32'h40, 32'h0, 32'h03, 22'h000001, 3, 32'hDEADBEEF);
    exec(32'h108, 32'h80, 32'h55, 32'h23, 22'h000002, 1, 32'hFFFFFFFF);
    // Back-to-back load then store (both control bits set -> store).
    exec(32'h10C, 32'h44, 32'h0, 32'h83, 22'h2A0001, 1, 32'h0BADF00D);
    exec(32'h110, 32'h48, 32'h66, 32'hA3, 22'h000003, 1, 32'h12345678);

    for (int n = 0; n < 10; n++) begin
      logic [21:0] c;
      c = 22'($urandom);
      exec($urandom, $urandom, $urandom, $urandom, c, $urandom_range(1, 4), $urandom);
    end

    // Ready on the last permitted cycle completes normally.
    exec(32'h200, 32'h90, 32'h0, 32'h03, 22'h000001, T_OUT, 32'hCAFEF00D);
    @(negedge clk);
    check("err_boundary", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    exec(32'h204, 32'hA0, 32'h0, 32'h03, 22'h000001, 0, 32'h0);
    @(negedge clk);
    check("err_timeout", 32'(err),     32'd1);
    check("req_timeout", 32'(mem_req), 32'd0);
    late_pulse = 1'b1;
    @(posedge clk);
    #2;
    late_pulse = 1'b0;
    // A stray ready lands in the IDLE cycle of this load and must be ignored.
    exec(32'h208, 32'hB0, 32'h0, 32'h03, 22'h000001, 2, 32'h5A5A5A5A);
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    @(posedge clk);
    #1;
    ex_pc = 32'h300; ex_alu = 32'h200; ex_instr = 32'h03; ex_ctrl = 22'h000001;
    rsp_lat = 0;
    @(negedge clk);
    @(negedge clk);
    check("req_inflight", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_mem_req",  32'(mem_req),  32'd0);
    check("arst_err",      32'(err),      32'd0);
    check("arst_mem_addr", mem_addr,      32'd0);
    check("arst_rw_pc",    rw_pc,         32'd0);
    check("arst_rw_ld",    rw_ld,         32'd0);
    check("arst_rw_instr", rw_instr,      32'd0);
    check("arst_rw_ctrl",  32'(rw_ctrl),  32'd0);
    drive_nop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exec(32'h400, 32'h777, 32'h0, 32'h33, 22'h000010, 0, 32'h0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
